// File: rtl/register_bank_reader_if.sv
// rtl/register_bank_reader_if.sv - write port, burst request and beat stream of register_bank_reader
//
// Purpose: bundles every non-clock/reset signal of register_bank_reader.
// Ports (signals):
//   we, wr_addr, data_in           single-cycle write port
//   rd_start, rd_base, rd_len      burst request (rd_len = 0 means no request)
//   out_valid, out_ready           beat handshake
//   out_data, out_last             beat payload and final-beat flag
//   busy                           burst in progress
// Modports: master = writer/requester/consumer side, slave = the register bank.
interface register_bank_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH:0]   rd_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;

    modport master (
        output we, wr_addr, data_in, rd_start, rd_base, rd_len, out_ready,
        input  out_valid, out_data, out_last, busy
    );

    modport slave (
        input  we, wr_addr, data_in, rd_start, rd_base, rd_len, out_ready,
        output out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/register_bank_reader.sv
// rtl/register_bank_reader.sv - register bank with write port and burst read-out stream
//
// Purpose: DEPTH x DATA_WIDTH register bank. Entries are written one per cycle;
//   a burst request (base, length) streams entries base, base+1, ... (wrapping
//   modulo DEPTH) out one per accepted beat, flagging the final beat.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears entries, aborts any burst)
//   bus    register_bank_reader_if.slave (write port, burst request, beat stream)
// Optional feature: define READ_CLEAR_EN to clear each entry on the edge its
//   beat transfers (a same-edge write to that entry takes priority).
module register_bank_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    register_bank_reader_if.slave   bus
);
    localparam int RW = ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [RW-1:0]         remaining;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  start_ok;
    logic                  xfer;
    logic                  xfer_last;

    // DEPTH is a power of two, so the natural overflow of the adder gives the wrap.
    assign next_addr = cur_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        xfer       = 1'b0;
        xfer_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rd_start && (bus.rd_len != '0)) begin
                    start_ok   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // rd_start is not looked at here, so a request during a burst
                // (including on the final transfer) is dropped.
                if (bus.out_ready) begin
                    xfer = 1'b1;
                    if (remaining == RW'(1)) begin
                        xfer_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat payload is captured when presented and only changes on a transfer,
    // so it stays stable through stalls regardless of writes to the bank.
    // The capture reads mem before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            remaining  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else if (start_ok) begin
            cur_addr   <= bus.rd_base;
            remaining  <= bus.rd_len;
            out_data_q <= mem[bus.rd_base];
            out_last_q <= (bus.rd_len == RW'(1));
        end else if (xfer) begin
            if (xfer_last) begin
                out_last_q <= 1'b0;
            end else begin
                cur_addr   <= next_addr;
                remaining  <= remaining - RW'(1);
                out_data_q <= mem[next_addr];
                out_last_q <= (remaining == RW'(2));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
`ifdef READ_CLEAR_EN
            if (xfer) begin
                mem[cur_addr] <= '0;
            end
`endif
            // Placed last so a same-edge write overrides the read-clear.
            if (bus.we) begin
                mem[bus.wr_addr] <= bus.data_in;
            end
        end
    end

    assign bus.out_valid = (state == SEND);
    assign bus.busy      = (state == SEND);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_register_bank_reader.sv
// tb/tb_register_bank_reader.sv - self-checking bench for register_bank_reader
module tb_register_bank_reader;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    register_bank_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_bank_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Burst-level reference: bank contents plus the beat currently on offer.
    int m_mem [DEPTH];
    bit m_act  = 1'b0;
    int m_addr = 0;
    int m_left = 0;
    int m_data = 0;
    bit m_last = 1'b0;

    typedef struct {
        bit we; int wa; int din;
        bit st; int base; int len; bit rdy;
        bit ev; int ed; bit el;
    } vec_t;

    vec_t tab [22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic drive(input bit we, input int wa, input int din, input bit st,
                         input int base, input int len, input bit rdy);
        bus.we        = we;
        bus.wr_addr   = AW'(wa);
        bus.data_in   = DW'(din);
        bus.rd_start  = st;
        bus.rd_base   = AW'(base);
        bus.rd_len    = (AW+1)'(len);
        bus.out_ready = rdy;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_act = 0; m_addr = 0; m_left = 0; m_data = 0; m_last = 0;
    endtask

    // Advance the reference by one clock from the driven inputs, clock the DUT,
    // then compare all outputs.
    task automatic step();
        int pre [DEPTH];
        bit x;
        int xa;
        pre = m_mem;
        x = 0;
        xa = 0;
        if (m_act) begin
            if (bus.out_ready) begin
                x = 1; xa = m_addr;
                if (m_left == 1) begin
                    m_act = 0; m_last = 0;
                end else begin
                    m_addr = (m_addr + 1) % DEPTH;
                    m_left = m_left - 1;
                    m_data = pre[m_addr];
                    m_last = (m_left == 1);
                end
            end
        end else if (bus.rd_start && bus.rd_len != 0) begin
            m_act  = 1;
            m_addr = int'(bus.rd_base);
            m_left = int'(bus.rd_len);
            m_data = pre[m_addr];
            m_last = (m_left == 1);
        end
`ifdef READ_CLEAR_EN
        if (x) m_mem[xa] = 0;
`endif
        if (bus.we) m_mem[int'(bus.wr_addr)] = int'(bus.data_in);
        @(posedge clk);
        #1;
        chk("model_valid", int'(bus.out_valid), int'(m_act));
        chk("model_busy",  int'(bus.busy),      int'(m_act));
        chk("model_last",  int'(bus.out_last),  int'(m_last));
        chk("model_data",  int'(bus.out_data),  m_data);
    endtask

    function automatic vec_t mk(bit we, int wa, int din, bit st, int base, int len,
                                bit rdy, bit ev, int ed, bit el);
        vec_t v;
        v.we = we; v.wa = wa; v.din = din; v.st = st; v.base = base; v.len = len;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el;
        return v;
    endfunction

    initial begin
        //            we wa din   st b  l  rdy  ev ed    el
        tab[0]  = mk(0, 0, 0,    1, 0, 4, 1,   1, 1,    0);
        tab[1]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 2,    0);
        tab[2]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 3,    0);
        tab[3]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 4,    1);
        tab[4]  = mk(0, 0, 0,    1, 2, 1, 1,   0, 4,    0);
        tab[5]  = mk(0, 0, 0,    0, 0, 0, 1,   0, 4,    0);
        tab[6]  = mk(0, 0, 0,    1, 6, 4, 1,   1, 7,    0);
        tab[7]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 8,    0);
        tab[8]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 1,    0);
        tab[9]  = mk(0, 0, 0,    0, 0, 0, 1,   1, 2,    1);
        tab[10] = mk(0, 0, 0,    0, 0, 0, 1,   0, 2,    0);
        tab[11] = mk(0, 0, 0,    1, 0, 3, 1,   1, 1,    0);
        tab[12] = mk(0, 0, 0,    0, 0, 0, 1,   1, 2,    0);
        tab[13] = mk(1, 1, 'hAA, 0, 0, 0, 0,   1, 2,    0);
        tab[14] = mk(0, 0, 0,    0, 0, 0, 0,   1, 2,    0);
        tab[15] = mk(0, 0, 0,    0, 0, 0, 0,   1, 2,    0);
        tab[16] = mk(0, 0, 0,    0, 0, 0, 1,   1, 3,    1);
        tab[17] = mk(0, 0, 0,    0, 0, 0, 1,   0, 3,    0);
        tab[18] = mk(0, 0, 0,    1, 0, 2, 0,   1, 1,    0);
        tab[19] = mk(0, 0, 0,    1, 5, 3, 1,   1, 'hAA, 1);
        tab[20] = mk(0, 0, 0,    1, 3, 0, 1,   0, 'hAA, 0);
        tab[21] = mk(0, 0, 0,    1, 3, 0, 1,   0, 'hAA, 0);

        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #12;
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_busy",  int'(bus.busy),      0);
        chk("reset_data",  int'(bus.out_data),  0);
        chk("reset_last",  int'(bus.out_last),  0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i, i + 1, 0, 0, 0, 1);
            step();
        end

`ifndef READ_CLEAR_EN
        for (int i = 0; i < 22; i++) begin
            drive(tab[i].we, tab[i].wa, tab[i].din, tab[i].st, tab[i].base,
                  tab[i].len, tab[i].rdy);
            step();
            chk($sformatf("tab%0d_valid", i), int'(bus.out_valid), int'(tab[i].ev));
            chk($sformatf("tab%0d_busy", i),  int'(bus.busy),      int'(tab[i].ev));
            chk($sformatf("tab%0d_data", i),  int'(bus.out_data),  tab[i].ed);
            chk($sformatf("tab%0d_last", i),  int'(bus.out_last),  int'(tab[i].el));
        end
`endif

        // Reset mid-burst, after the first beat has transferred.
        drive(0, 0, 0, 1, 0, 4, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_busy",  int'(bus.busy),      0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_hold_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 8, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            drive(0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("cleared_beat%0d", i), int'(bus.out_data), 0);
            chk($sformatf("cleared_valid%0d", i), int'(bus.out_valid), 1);
        end
        step();
        chk("cleared_done", int'(bus.busy), 0);

`ifdef READ_CLEAR_EN
        drive(1, 0, 'h11, 0, 0, 0, 1); step();
        drive(1, 1, 'h22, 0, 0, 0, 1); step();
        drive(0, 0, 0, 1, 0, 2, 1);    step();
        chk("rc_first0", int'(bus.out_data), 'h11);
        drive(0, 0, 0, 0, 0, 0, 1);    step();
        chk("rc_first1", int'(bus.out_data), 'h22);
        drive(1, 1, 'h55, 0, 0, 0, 1); step();
        chk("rc_first_end", int'(bus.busy), 0);
        drive(0, 0, 0, 1, 0, 2, 1);    step();
        chk("rc_second0", int'(bus.out_data), 0);
        drive(0, 0, 0, 0, 0, 0, 1);    step();
        chk("rc_second1", int'(bus.out_data), 'h55);
        chk("rc_second1_last", int'(bus.out_last), 1);
        step();
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) == 0, $urandom % DEPTH, $urandom % 256,
                  ($urandom % 4) == 0, $urandom % DEPTH, $urandom_range(0, 12),
                  ($urandom % 4) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
